// File: rtl/gshare_predictor_if.sv
`default_nettype none
// ============================================================================
//  Module   : gshare_predictor_if
//  Brief    : Predict/resolve bundle between Ins-Fetch and the gshare predictor.
//             Stats ports exist only when BP_STATS_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface gshare_predictor_if #(
    parameter int PC_W   = 32,
    parameter int HIST_W = 6
);
    logic              en;
    logic [PC_W-1:0]   if_pc_i;
    logic              if_req_i;
    logic              if_br_o;
    logic [HIST_W-1:0] if_hist_o;
    logic              if_en_i;
    logic              if_abr_i;
    logic [PC_W-1:0]   if_tpc_i;
    logic [HIST_W-1:0] if_thist_i;
    logic              if_mis_i;
`ifdef BP_STATS_EN
    logic [31:0]       stat_br_o;
    logic [31:0]       stat_mis_o;
`endif

    modport master (
        output en, if_pc_i, if_req_i, if_en_i, if_abr_i, if_tpc_i, if_thist_i, if_mis_i,
        input  if_br_o, if_hist_o
`ifdef BP_STATS_EN
        , input stat_br_o, stat_mis_o
`endif
    );

    modport slave (
        input  en, if_pc_i, if_req_i, if_en_i, if_abr_i, if_tpc_i, if_thist_i, if_mis_i,
        output if_br_o, if_hist_o
`ifdef BP_STATS_EN
        , output stat_br_o, stat_mis_o
`endif
    );
endinterface
`default_nettype wire

// File: rtl/gshare_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : gshare_predictor
//  Brief    : Gshare branch predictor: PC xor GHR indexes saturating counters.
//             Optional macro BP_STATS_EN adds resolve/mispredict counters.
//  Revision : 1.0  initial release
// ============================================================================
module gshare_predictor #(
    parameter int PC_W   = 32,
    parameter int IDX_W  = 6,
    parameter int CNT_W  = 2,
    parameter int HIST_W = 6
) (
    input  wire logic          clk,
    input  wire logic          rst,
    gshare_predictor_if.slave  bp
);

    localparam int               c_entries  = 1 << IDX_W;
    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

    logic [CNT_W-1:0]  r_cnt [c_entries];
    logic [HIST_W-1:0] r_ghr;

    logic [IDX_W-1:0]  w_pidx;
    logic [IDX_W-1:0]  w_tidx;
    logic [CNT_W-1:0]  w_tcnt;
    logic [CNT_W-1:0]  w_tcnt_next;
    logic              w_unused;

    assign w_pidx       = bp.if_pc_i[IDX_W+1:2]  ^ IDX_W'(r_ghr);
    assign w_tidx       = bp.if_tpc_i[IDX_W+1:2] ^ IDX_W'(bp.if_thist_i);
    assign w_tcnt       = r_cnt[w_tidx];

    // Prediction reads the table before this cycle's training lands (no bypass).
    assign bp.if_br_o   = r_cnt[w_pidx][CNT_W-1];
    assign bp.if_hist_o = r_ghr;

    // Only the index slices of the PCs are meaningful; the rest is aliasing.
    assign w_unused     = ^{bp.if_pc_i, bp.if_tpc_i, bp.if_thist_i};

    always_comb begin
        w_tcnt_next = w_tcnt;
        if (bp.if_abr_i) begin
            if (w_tcnt != c_cnt_max) w_tcnt_next = w_tcnt + 1'b1;
        end else begin
            if (w_tcnt != '0)        w_tcnt_next = w_tcnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_entries; i++) r_cnt[i] <= c_cnt_init;
            r_ghr <= '0;
        end else if (bp.en) begin
            if (bp.if_en_i) r_cnt[w_tidx] <= w_tcnt_next;
            // Repair beats the speculative shift; the flushed fetch never counts.
            if (bp.if_en_i && bp.if_mis_i)
                r_ghr <= HIST_W'({bp.if_thist_i, bp.if_abr_i});
            else if (bp.if_req_i)
                r_ghr <= HIST_W'({r_ghr, bp.if_br_o});
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] r_stat_br;
    logic [31:0] r_stat_mis;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_br  <= '0;
            r_stat_mis <= '0;
        end else if (bp.en && bp.if_en_i) begin
            if (r_stat_br != 32'hFFFF_FFFF) r_stat_br <= r_stat_br + 32'd1;
            if (bp.if_mis_i && (r_stat_mis != 32'hFFFF_FFFF))
                r_stat_mis <= r_stat_mis + 32'd1;
        end
    end

    assign bp.stat_br_o  = r_stat_br;
    assign bp.stat_mis_o = r_stat_mis;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gshare_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gshare_predictor
//  Brief    : Scoreboard bench for gshare_predictor against an arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gshare_predictor;

    localparam int PC_W   = 32;
    localparam int IDX_W  = 6;
    localparam int CNT_W  = 2;
    localparam int HIST_W = 6;
    localparam int ENT    = 1 << IDX_W;
    localparam int HENT   = 1 << HIST_W;
    localparam int CMAX   = (1 << CNT_W) - 1;
    localparam int CHALF  = 1 << (CNT_W - 1);

    logic clk;
    logic rst;

    gshare_predictor_if #(.PC_W(PC_W), .HIST_W(HIST_W)) bus ();

    gshare_predictor #(
        .PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W), .HIST_W(HIST_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit    chk;
        bit    br;
        int    hist;
        longint sbr;
        longint smis;
        string tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: plain integers, counters as numbers, history as a number.
    int     m_cnt [ENT];
    int     m_ghr;
    longint m_sbr;
    longint m_smis;

    function automatic int pidx(input logic [31:0] pc, input int h);
        return (int'(pc >> 2) ^ h) % ENT;
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_cnt[pidx(pc, m_ghr)] >= CHALF;
    endfunction

    task automatic m_apply(input bit r, input bit e, input logic [31:0] pc, input bit req,
                           input bit fen, input bit abr, input logic [31:0] tpc,
                           input int th, input bit mis);
        int t;
        bit p;
        if (r) begin
            for (int i = 0; i < ENT; i++) m_cnt[i] = CHALF;
            m_ghr  = 0;
            m_sbr  = 0;
            m_smis = 0;
        end else if (e) begin
            p = m_pred(pc);
            if (fen) begin
                t = pidx(tpc, th);
                m_cnt[t] = abr ? ((m_cnt[t] + 1 > CMAX) ? CMAX : m_cnt[t] + 1)
                               : ((m_cnt[t] - 1 < 0) ? 0 : m_cnt[t] - 1);
                if (m_sbr < 64'hFFFF_FFFF) m_sbr++;
                if (mis && m_smis < 64'hFFFF_FFFF) m_smis++;
            end
            if (fen && mis)  m_ghr = (th * 2 + int'(abr)) % HENT;
            else if (req)    m_ghr = (m_ghr * 2 + int'(p)) % HENT;
        end
    endtask

    task automatic step(input bit r, input bit e, input logic [31:0] pc, input bit req,
                        input bit fen, input bit abr, input logic [31:0] tpc,
                        input int th, input bit mis, input bit chk, input string tag);
        exp_t x;
        @(posedge clk);
        #1;
        rst            = r;
        bus.en         = e;
        bus.if_pc_i    = pc;
        bus.if_req_i   = req;
        bus.if_en_i    = fen;
        bus.if_abr_i   = abr;
        bus.if_tpc_i   = tpc;
        bus.if_thist_i = HIST_W'(th);
        bus.if_mis_i   = mis;
        x.chk  = chk;
        x.br   = m_pred(pc);
        x.hist = m_ghr;
        x.sbr  = m_sbr;
        x.smis = m_smis;
        x.tag  = tag;
        q.push_back(x);
        m_apply(r, e, pc, req, fen, abr, tpc, th, mis);
    endtask

    // Monitor: outputs are combinational, so every cycle presents one response.
    always @(negedge clk) begin
        exp_t x;
        if (q.size() > 0) begin
            x = q.pop_front();
            if (x.chk) begin
                checks++;
                if (bus.if_br_o !== x.br) begin
                    errors++;
                    $display("FAIL %s if_br_o: got %b expected %b", x.tag, bus.if_br_o, x.br);
                end
                checks++;
                if (bus.if_hist_o !== HIST_W'(x.hist)) begin
                    errors++;
                    $display("FAIL %s if_hist_o: got %h expected %h", x.tag, bus.if_hist_o,
                             HIST_W'(x.hist));
                end
`ifdef BP_STATS_EN
                checks++;
                if (bus.stat_br_o !== 32'(x.sbr) || bus.stat_mis_o !== 32'(x.smis)) begin
                    errors++;
                    $display("FAIL %s stats: got %0d/%0d expected %0d/%0d", x.tag,
                             bus.stat_br_o, bus.stat_mis_o, x.sbr, x.smis);
                end
`endif
            end
        end
    end

    initial begin
        rst            = 1'b1;
        bus.en         = 1'b0;
        bus.if_pc_i    = '0;
        bus.if_req_i   = 1'b0;
        bus.if_en_i    = 1'b0;
        bus.if_abr_i   = 1'b0;
        bus.if_tpc_i   = '0;
        bus.if_thist_i = '0;
        bus.if_mis_i   = 1'b0;
        m_ghr  = 0;
        m_sbr  = 0;
        m_smis = 0;
        for (int i = 0; i < ENT; i++) m_cnt[i] = CHALF;

        // Reset, then weakly-taken prediction with empty history
        step(1, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0, "rst");
        step(0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 1, "reset_pred");
        // Frozen while en is low, despite feedback and requests
        for (int i = 0; i < 5; i++)
            step(0, 0, 32'h40, 1, 1, 0, 32'h40, 0, 1, 1, "en_low");
        step(0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 1, "after_en_low");

        // Saturate down, then up, on entry 0x10
        for (int i = 0; i < 3; i++)
            step(0, 1, 32'h40, 0, 1, 0, 32'h40, 0, 0, 1, "train_nt");
        for (int i = 0; i < 4; i++)
            step(0, 1, 32'h40, 0, 1, 1, 32'h40, 0, 0, 1, "train_t");
        step(0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 1, "train_done");

        // Speculative history shift from reset
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, "rst2");
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 1, 0, 0, 0, 0, 0, 1, "spec_shift");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, "hist_07");

        // Mispredict repair overrides a same-cycle request
        step(0, 1, 0, 1, 1, 0, 32'h80, 'h15, 1, 1, "repair");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, "repaired");
        step(0, 1, 32'h80, 0, 0, 0, 0, 0, 0, 1, "repair_entry");

        // Same-cycle predict and train: no bypass
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, "rst3");
        step(0, 1, 32'h40, 0, 1, 0, 32'h40, 0, 0, 1, "nobypass");
        step(0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 1, "nobypass_next");

        // Stats: ten resolves, three mispredicted
        for (int i = 0; i < 10; i++)
            step(0, 1, $urandom, 0, 1, i[0], $urandom, 0, (i < 3), 1, "stats");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, "stats_done");
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, "stats_rst");

        // Randomized traffic with occasional reset and enable drops
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
                 {$urandom} & 32'h0000_01FC, $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), {$urandom} & 32'h0000_01FC,
                 $urandom_range(0, HENT - 1), ($urandom_range(0, 3) == 0), 1, "random");
        end

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised successor to the bimodal 2-bit predictor used by Ins-Fetch.
- Table of 2^IDX_W saturating counters of CNT_W bits, indexed by PC bits XOR a global history register (GHR).
- GHR is updated speculatively at predict time and repaired on a mispredict.
- Sits beside Ins-Fetch: combinational predict path, registered training/repair path.

Parameters:
- PC_W, 32, PC width; tie to `RAM_ADR_W at instantiation.
- IDX_W, 6, table index width; entries = 2^IDX_W; legal 2..10.
- CNT_W, 2, counter width; legal 1..4.
- HIST_W, 6, GHR width; legal 1..IDX_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en  in  1  global enable (rdy); when low, state is frozen
- if_pc_i  in  PC_W  PC being predicted
- if_req_i  in  1  IF consumes this prediction this cycle (conditional branch fetched)
- if_br_o  out  1  predicted taken
- if_hist_o  out  HIST_W  current GHR; IF carries it with the instruction
- if_en_i  in  1  resolve feedback valid
- if_abr_i  in  1  branch actually taken
- if_tpc_i  in  PC_W  PC of the resolved branch
- if_thist_i  in  HIST_W  GHR value returned with the resolved branch
- if_mis_i  in  1  resolved branch was mispredicted (qualified by if_en_i)

Behaviour:
- Predict index = if_pc_i[IDX_W+1:2] XOR zero-extend(ghr) to IDX_W. Combinational.
- if_br_o = MSB of the counter at the predict index; if_hist_o = ghr. Both are combinational, so outputs follow the reset table and GHR with no latency.
- Train index = if_tpc_i[IDX_W+1:2] XOR zero-extend(if_thist_i).
- Reset (rst=1 at posedge):
  - Every counter = 2^(CNT_W-1) (weakly taken).
  - ghr = 0.
  - Therefore if_br_o = 1 and if_hist_o = 0 in the first cycle after reset.
  - Reset overrides en and all feedback; an update in flight during reset is dropped.
- en=0: no counter or GHR writes. Outputs remain valid combinationally.
- Training, on posedge with en & if_en_i:
  - Taken: increment, saturating at 2^CNT_W-1.
  - Not taken: decrement, saturating at 0.
  - Exactly one entry is written per cycle.
- GHR update on posedge with en, in priority order:
  1. if_en_i & if_mis_i: ghr <= {if_thist_i[HIST_W-2:0], if_abr_i} (repair; HIST_W=1 gives ghr <= if_abr_i).
  2. else if_req_i: ghr <= {ghr[HIST_W-2:0], if_br_o} (speculative shift).
  3. else: hold.
- A request in the same cycle as a mispredict is discarded from history; IF flushes that fetch anyway.
- Same-cycle predict and train of the same entry: prediction uses the pre-update counter (no bypass). The updated value is visible from the next cycle.
- Wrap-around: index bits beyond IDX_W are ignored; aliasing is permitted.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - Adds outputs stat_br_o (32) and stat_mis_o (32).
  - stat_br_o increments on each en & if_en_i; stat_mis_o increments on each en & if_en_i & if_mis_i.
  - Both saturate at 32'hFFFFFFFF, reset to 0 on rst, and are registered (visible the cycle after the event).
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan (defaults: IDX_W=6, CNT_W=2, HIST_W=6):
1. Reset, then if_pc_i=0x40 with no req -> if_br_o=1, if_hist_o=0; with en=0 for 5 cycles and feedback asserted -> no state change.
2. ghr=0; three trainings: tpc=0x40, thist=0, abr=0 -> counter at index 0x10 goes 10->01->00->00 (saturates); predict pc=0x40 -> if_br_o=0. Four taken trainings -> 00->01->10->11->11; if_br_o=1.
3. From reset, pulse if_req_i 3 cycles with pc=0x0 (prediction 1 each cycle) -> if_hist_o = 0x01, 0x03, 0x07 after each edge; predict pc=0x0 now indexes entry 0x07.
4. ghr=0x07; if_en_i=1, if_mis_i=1, if_thist_i=0x15, if_abr_i=0, with if_req_i=1 the same cycle -> ghr=0x2A (repair wins, request ignored); counter at index (tpc[7:2]^0x15) decremented.
5. Same cycle: predict pc=0x40 with ghr=0 and train tpc=0x40, thist=0 toward not taken from counter 10 -> if_br_o=1 that cycle, 0 the next cycle.
6. BP_STATS_EN: 10 resolves, 3 with if_mis_i -> stat_br_o=10, stat_mis_o=3; rst -> both 0; force 32'hFFFFFFFF then one more resolve -> holds 32'hFFFFFFFF.
